// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the CDC read side, the BCD converter and the display mux.
// The producer side (master) drives the word and the abort; the converter (slave)
// answers with readiness, the completion pulse and the registered digits/blank mask.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  clear;
   logic                  in_valid;
   logic [WIDTH-1:0]      in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;

   modport master (
      output clear,
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  bcd,
      input  blank
   );

   modport slave (
      input  clear,
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output bcd,
      output blank
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// A word is accepted in IDLE, shifted through WIDTH add-3/shift iterations in
// SHIFT, and the final digits plus a leading-zero blanking mask are published
// with a single-cycle out_valid pulse. clear aborts the conversion in flight
// without touching the published outputs.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   bin_to_bcd_seq_if.slave     bus
);

   localparam int                 BCD_W     = 4 * DIGITS;
   localparam int                 CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);
   // Every digit except the units digit is blanked while the value is zero.
   localparam logic [DIGITS-1:0]  BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               state_q,     state_d;
   logic [WIDTH-1:0]     bin_sr_q,    bin_sr_d;
   logic [BCD_W-1:0]     bcd_sr_q,    bcd_sr_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [BCD_W-1:0]     bcd_q,       bcd_d;
   logic [DIGITS-1:0]    blank_q,     blank_d;
   logic                 out_valid_q, out_valid_d;

   // One double-dabble step on the current shift registers.
   logic [BCD_W-1:0]     adj_bcd;
   logic [BCD_W-1:0]     step_bcd;
   logic [WIDTH-1:0]     step_bin;
   logic [DIGITS-1:0]    step_blank;
   logic                 seen_nonzero;

   // Add-3 correction per nibble, then the combined {bcd, bin} left shift,
   // and the blanking mask of the shifted digits (used only on the last step).
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // it unassigned -- otherwise synthesis infers a latch to hold the old value.
      adj_bcd      = bcd_sr_q;
      step_blank   = '0;
      seen_nonzero = 1'b0;

      for (int i = 0; i < DIGITS; i++) begin
         // Nibbles are corrected independently; a 4-bit add of 3 to 5..9 never carries.
         if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
            adj_bcd[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
         end
      end

      step_bcd = {adj_bcd[BCD_W-2:0], bin_sr_q[WIDTH-1]};
      step_bin = {bin_sr_q[WIDTH-2:0], 1'b0};

      // Scan from the most significant digit: a digit is blank while every
      // digit above it (and itself) is zero. The units digit always shows.
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (step_bcd[4*i +: 4] != 4'd0) begin
            seen_nonzero = 1'b1;
         end
         step_blank[i] = ~seen_nonzero;
      end
   end

   // Next-state and register-update decisions for the IDLE/SHIFT controller.
   always_comb begin
      state_d     = state_q;
      bin_sr_d    = bin_sr_q;
      bcd_sr_d    = bcd_sr_q;
      cnt_d       = cnt_q;
      bcd_d       = bcd_q;
      blank_d     = blank_q;
      out_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // clear has priority over a word offered in the same cycle.
            if (bus.in_valid && !bus.clear) begin
               bin_sr_d = bus.in_data;
               bcd_sr_d = '0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            // in_valid is deliberately ignored here; in_ready is low so the
            // producer must hold or re-offer its word.
            if (bus.clear) begin
               state_d = IDLE;
            end else begin
               bin_sr_d = step_bin;
               bcd_sr_d = step_bcd;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  bcd_d       = step_bcd;
                  blank_d     = step_blank;
                  out_valid_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shift registers and published outputs; async reset discards any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bin_sr_q    <= '0;
         bcd_sr_q    <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         blank_q     <= BLANK_ZERO;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q     <= state_d;
         bin_sr_q    <= bin_sr_d;
         bcd_sr_q    <= bcd_sr_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         blank_q     <= blank_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready is decoded from the state so it rises in the same cycle as out_valid.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.bcd       = bcd_q;
   assign bus.blank     = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: hand-computed BCD/blank vectors,
// latency, back-to-back acceptance, ignored input during SHIFT, clear and
// asynchronous reset in mid-conversion.
module tb_bin_to_bcd_seq;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer a word just after an edge; returns #1 after the accept edge E0.
   task automatic send_word(input logic [WIDTH-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts edges until out_valid is seen (#1 after the edge); -1 on timeout.
   task automatic wait_pulse(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            n = i;
            break;
         end
      end
   endtask

   // Counts out_valid pulses over a fixed number of cycles.
   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) n++;
      end
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      n_checks++;
      if (bus.bcd !== 20'h00000) begin
         n_errors++; $display("FAIL reset_bcd: got %h expected 00000", bus.bcd);
      end
      n_checks++;
      if (bus.blank !== 5'b11110) begin
         n_errors++; $display("FAIL reset_blank: got %b expected 11110", bus.blank);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero;
      int n;
      send_word(16'd0);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL zero_busy: in_ready got %b expected 0", bus.in_ready);
      end
      wait_pulse(n);
      n_checks++;
      if (n !== 16) begin
         n_errors++; $display("FAIL zero_latency: pulse after %0d edges, expected 16", n);
      end
      n_checks++;
      if (bus.bcd !== 20'h00000) begin
         n_errors++; $display("FAIL zero_bcd: got %h expected 00000", bus.bcd);
      end
      n_checks++;
      if (bus.blank !== 5'b11110) begin
         n_errors++; $display("FAIL zero_blank: got %b expected 11110", bus.blank);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL zero_ready_at_pulse: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_max;
      int n;
      send_word(16'd65535);
      wait_pulse(n);
      n_checks++;
      if (n !== 16) begin
         n_errors++; $display("FAIL max_latency: pulse after %0d edges, expected 16", n);
      end
      n_checks++;
      if (bus.bcd !== 20'h65535) begin
         n_errors++; $display("FAIL max_bcd: got %h expected 65535", bus.bcd);
      end
      n_checks++;
      if (bus.blank !== 5'b00000) begin
         n_errors++; $display("FAIL max_blank: got %b expected 00000", bus.blank);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++; $display("FAIL max_pulse_width: out_valid got %b expected 0", bus.out_valid);
      end
   endtask

   // A few more vectors with distinct blanking patterns.
   task automatic test_vectors;
      logic [WIDTH-1:0]    vin [4]  = '{16'd10, 16'd100, 16'd9999, 16'd59999};
      logic [4*DIGITS-1:0] vbcd [4] = '{20'h00010, 20'h00100, 20'h09999, 20'h59999};
      logic [DIGITS-1:0]   vblk [4] = '{5'b11100, 5'b11000, 5'b10000, 5'b00000};
      int n;
      for (int k = 0; k < 4; k++) begin
         send_word(vin[k]);
         wait_pulse(n);
         n_checks++;
         if (n !== 16 || bus.bcd !== vbcd[k] || bus.blank !== vblk[k]) begin
            n_errors++;
            $display("FAIL vector_%0d: in=%0d edges=%0d bcd=%h blank=%b expected edges=16 bcd=%h blank=%b",
                     k, vin[k], n, bus.bcd, bus.blank, vbcd[k], vblk[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd1234;
      @(posedge clk);          // E0
      #1;
      bus.in_data  = 16'd9;    // in_valid stays high through the whole conversion
      wait_pulse(n);
      n_checks++;
      if (n !== 16 || bus.bcd !== 20'h01234 || bus.blank !== 5'b10000) begin
         n_errors++;
         $display("FAIL b2b_first: edges=%0d bcd=%h blank=%b expected edges=16 bcd=01234 blank=10000",
                  n, bus.bcd, bus.blank);
      end
      @(posedge clk);          // E17: second word accepted
      #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL b2b_accept: in_ready got %b expected 0", bus.in_ready);
      end
      wait_pulse(n);
      n_checks++;
      if (n !== 16 || bus.bcd !== 20'h00009 || bus.blank !== 5'b11110) begin
         n_errors++;
         $display("FAIL b2b_second: edges=%0d bcd=%h blank=%b expected edges=16 bcd=00009 blank=11110",
                  n, bus.bcd, bus.blank);
      end
   endtask

   task automatic test_ignore_busy;
      int n;
      int extra;
      send_word(16'd42);
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL busy_in_ready: got %b expected 0", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd777;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_pulse(n);
      n_checks++;
      if (n !== 10 || bus.bcd !== 20'h00042 || bus.blank !== 5'b11100) begin
         n_errors++;
         $display("FAIL busy_result: edges=%0d bcd=%h blank=%b expected edges=10 bcd=00042 blank=11100",
                  n, bus.bcd, bus.blank);
      end
      count_pulses(20, extra);
      n_checks++;
      if (extra !== 0) begin
         n_errors++; $display("FAIL busy_no_queue: %0d extra pulses, expected 0", extra);
      end
   endtask

   task automatic test_clear;
      int n;
      // Abort at iteration 8: clear sampled on E8.
      send_word(16'd4321);
      repeat (7) @(posedge clk);
      #1;
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bcd !== 20'h00042) begin
         n_errors++;
         $display("FAIL clear_abort: in_ready=%b out_valid=%b bcd=%h expected 1 0 00042",
                  bus.in_ready, bus.out_valid, bus.bcd);
      end
      // clear still high while a word is offered in IDLE: not accepted.
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd5;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL clear_idle_priority: in_ready got %b expected 1", bus.in_ready);
      end
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      count_pulses(20, n);
      n_checks++;
      if (n !== 0 || bus.bcd !== 20'h00042) begin
         n_errors++; $display("FAIL clear_no_pulse: pulses=%0d bcd=%h expected 0 00042", n, bus.bcd);
      end
      // clear on the completion edge E16 suppresses the result.
      send_word(16'd4321);
      repeat (15) @(posedge clk);
      #1;
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.bcd !== 20'h00042 || bus.blank !== 5'b11100) begin
         n_errors++;
         $display("FAIL clear_last_edge: out_valid=%b bcd=%h blank=%b expected 0 00042 11100",
                  bus.out_valid, bus.bcd, bus.blank);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      send_word(16'd4321);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.bcd !== 20'h00000 || bus.blank !== 5'b11110) begin
         n_errors++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b bcd=%h blank=%b expected 1 0 00000 11110",
                  bus.in_ready, bus.out_valid, bus.bcd, bus.blank);
      end
      @(negedge clk);
      rst_n = 1'b1;
      count_pulses(25, n);
      n_checks++;
      if (n !== 0) begin
         n_errors++; $display("FAIL reset_stale_pulse: %0d pulses, expected 0", n);
      end
      // The converter works normally after the reset.
      send_word(16'd4321);
      wait_pulse(n);
      n_checks++;
      if (n !== 16 || bus.bcd !== 20'h04321 || bus.blank !== 5'b10000) begin
         n_errors++;
         $display("FAIL reset_recover: edges=%0d bcd=%h blank=%b expected edges=16 bcd=04321 blank=10000",
                  n, bus.bcd, bus.blank);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_zero();
      test_max();
      test_vectors();
      test_back_to_back();
      test_ignore_busy();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop if the run ever wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
